gyro_motion_detector: RTL
=========================

# gyro_motion_detector

Consumes the raw register bytes read from the MPU6050 by the I2C gyroscope reader and turns them into a debounced `mover` event for the pet state machine. It assembles big-endian bytes into signed 16-bit axis samples and takes the absolute value of each. It requires a configurable number of consecutive over-threshold frames, then asserts `mover` for a fixed hold time followed by a cooldown. It sits directly downstream of the I2C read stage and upstream of the game FSM.

## Interface
- `THRESHOLD`, 2000: unsigned magnitude, compared with strict `>`, per axis.
- `CONFIRM_FRAMES`, 3: number of consecutive over-threshold frames needed to fire; range 1..15.
- `HOLD_CYCLES`, 25_000_000: number of clk cycles `mover` stays high (0.5 s at 50 MHz); ≥1.
- `HOLDOFF_CYCLES`, 50_000_000: cooldown after hold during which frames are ignored; ≥1.

Ports:
- `clk`  in  1  50 MHz system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  block active; low means synchronous return to idle.
- `byte_in`  in  8  register byte from the I2C reader.
- `byte_valid`  in  1  one-cycle strobe; `byte_in` is valid.
- `frame_start`  in  1  one-cycle strobe; the next or coincident byte is byte 0 of a frame.
- `gyro_x`, `gyro_y`  out  16  last assembled signed samples.
- `frame_valid`  out  1  one-cycle pulse when `gyro_x`/`gyro_y` are updated.
- `mover`  out  1  motion event level.

## Operation
- The frame is 4 bytes in order: XH, XL, YH, YL. A 2-bit byte index advances on each accepted `byte_valid` and wraps to 0 after YL.
- If `frame_start` and `byte_valid` occur in the same cycle, the byte is stored as index 0.
- If `frame_start` arrives alone mid-frame, the partial frame is discarded and the index is reset to 0.
- Samples latch only when the frame completes; partial frames never update the outputs.
- Magnitude is computed as |s|, with -32768 saturated to 32767.
- `over` = (|x| > THRESHOLD) || (|y| > THRESHOLD).
- States are IDLE, ARMING, ACTIVE and COOLDOWN:
  - IDLE: on a frame with `over` set, load the confirm count with 1. If CONFIRM_FRAMES==1, go to ACTIVE; otherwise go to ARMING.
  - ARMING: a frame with `over` set increments the count; reaching CONFIRM_FRAMES goes to ACTIVE. A frame without `over` clears the count and returns to IDLE.
  - ACTIVE: `mover`=1. Load the hold counter; after HOLD_CYCLES cycles go to COOLDOWN. Frames are ignored.
  - COOLDOWN: `mover`=0. After HOLDOFF_CYCLES cycles go to IDLE with the confirm count cleared. Frames still update `gyro_*` and `frame_valid` but do not affect the state.
- `enable`=0 forces the following in the next cycle: IDLE, byte index 0, all counters 0, `mover`=0. Bytes are ignored while `enable` is low. `gyro_*` hold their values.
- Counter widths are `$clog2(param+1)`. Every counter saturates and never wraps.

## Timing
- Reset values are: `mover`=0, `frame_valid`=0, `gyro_x`=`gyro_y`=0, state IDLE, byte index 0, counters 0.
- If the YL byte is strobed at cycle t:
  - `frame_valid` and the new `gyro_*` appear at t+1.
  - The magnitude compare is registered at t+1, and the state update occurs at t+2.
  - When that frame is the confirming one, `mover` rises at t+2.
- `mover` is high for exactly HOLD_CYCLES cycles, then low for at least HOLDOFF_CYCLES cycles.
- Back-to-back `byte_valid` on consecutive cycles is supported; no backpressure exists.
- When `reset` is asserted mid-hold, `mover` drops asynchronously.

## Configuration
- `GYRO_AXIS_Z_EN` defined:
  - The frame becomes 6 bytes (adds ZH, ZL), and the byte index widens to 3 bits with a wrap after 5.
  - A `gyro_z` output (16 bits) is added.
  - `over` includes |z| > THRESHOLD.
- Undefined: the frame is 4 bytes, there is no `gyro_z` port, and latency is identical.

## Structure
- The package `gyro_pkg` holds:
  - the state enum (IDLE, ARMING, ACTIVE, COOLDOWN);
  - the frame-length constant, which depends on the macro;
  - the byte-index constants;
  - the magnitude saturation constant 16'h7FFF.
- One sub-module, `gyro_frame_assembler`, covers byte indexing, resync and sample latching, and produces `frame_valid`/`gyro_*`.
- The top level holds the magnitude compare, the FSM and the counters.

## Test plan
Tests override the parameters to THRESHOLD=1000, CONFIRM_FRAMES=3, HOLD_CYCLES=4, HOLDOFF_CYCLES=8.
- Assembly: frame bytes 0x01,0x2C,0xFC,0x18 → `gyro_x`=300 and `gyro_y`=-1000, with a `frame_valid` pulse at t+1; `mover` stays 0.
- Confirm: three consecutive frames with x=0x07D0 (2000) → `mover` rises 2 cycles after the third YL, stays high exactly 4 cycles, and then no re-fire occurs within 8 cycles even with further over frames.
- Break: the sequence over, over, under (x=500, y=0), over → `mover` stays 0, and the count restarts at 1.
- Saturation/sign: x=0x8000, y=0 → counts as over. y=-1001 alone → over. x=1000, y=-1000 → not over.
- Resync: `frame_start` after 2 bytes, then a full frame of 0x00,0x64,0x00,0xC8 → `gyro_x`=100 and `gyro_y`=200; the partial bytes are dropped.
- Enable/reset: drop `enable` during ACTIVE → `mover`=0 next cycle, and the state is IDLE. Assert `reset` low mid-frame → all outputs are 0 immediately.

Source files
------------

// File: rtl/gyro_pkg.sv
// Shared types and constants for the gyro motion detector.
// Build option: GYRO_AXIS_Z_EN adds the Z axis (6-byte frame, gyro_z output).
package gyro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_COOLDOWN = 2'd3
    } gyro_state_e;

`ifdef GYRO_AXIS_Z_EN
    localparam int unsigned FRAME_LEN = 6;
    localparam int unsigned IDX_W     = 3;
`else
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned IDX_W     = 2;
`endif

    typedef logic [IDX_W-1:0] byte_idx_t;

    localparam byte_idx_t IDX_XH   = IDX_W'(0);
    localparam byte_idx_t IDX_XL   = IDX_W'(1);
    localparam byte_idx_t IDX_YH   = IDX_W'(2);
    localparam byte_idx_t IDX_YL   = IDX_W'(3);
`ifdef GYRO_AXIS_Z_EN
    localparam byte_idx_t IDX_ZH   = IDX_W'(4);
    localparam byte_idx_t IDX_ZL   = IDX_W'(5);
`endif
    localparam byte_idx_t IDX_LAST = IDX_W'(FRAME_LEN - 1);

    localparam logic [15:0] MAG_SAT = 16'h7FFF;

    // |s| of a two's-complement sample; -32768 saturates to 32767.
    function automatic logic [15:0] abs_sat(input logic [15:0] s);
        if (s == 16'h8000) begin
            return MAG_SAT;
        end else if (s[15]) begin
            return 16'(~s + 16'd1);
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/gyro_frame_assembler.sv
// Collects big-endian register bytes into per-axis samples; frame_start resyncs.
// Build option: GYRO_AXIS_Z_EN adds the Z axis bytes and gyro_z.
module gyro_frame_assembler
    import gyro_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        frame_start,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
`ifdef GYRO_AXIS_Z_EN
    output logic [15:0] gyro_z,
`endif
    output logic        frame_valid
);

    byte_idx_t   r_idx;
    byte_idx_t   w_idx_cur;
    logic        w_last;
    logic [7:0]  r_xh, r_xl, r_yh;
    logic [15:0] r_gx, r_gy;
    logic        r_fv;
`ifdef GYRO_AXIS_Z_EN
    logic [7:0]  r_yl, r_zh;
    logic [15:0] r_gz;
`endif

    // A coincident frame_start forces the incoming byte to slot 0.
    always_comb begin
        w_idx_cur = frame_start ? IDX_XH : r_idx;
        w_last    = (w_idx_cur == IDX_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= IDX_XH;
            r_fv  <= 1'b0;
            r_xh  <= 8'd0;
            r_xl  <= 8'd0;
            r_yh  <= 8'd0;
            r_gx  <= 16'd0;
            r_gy  <= 16'd0;
`ifdef GYRO_AXIS_Z_EN
            r_yl  <= 8'd0;
            r_zh  <= 8'd0;
            r_gz  <= 16'd0;
`endif
        end else if (!enable) begin
            r_idx <= IDX_XH;
            r_fv  <= 1'b0;
        end else begin
            r_fv <= 1'b0;
            if (byte_valid) begin
                case (w_idx_cur)
                    IDX_XH:  r_xh <= byte_in;
                    IDX_XL:  r_xl <= byte_in;
                    IDX_YH:  r_yh <= byte_in;
`ifdef GYRO_AXIS_Z_EN
                    IDX_YL:  r_yl <= byte_in;
                    IDX_ZH:  r_zh <= byte_in;
`endif
                    default: ;
                endcase
                // Outputs only move on a completed frame.
                if (w_last) begin
                    r_idx <= IDX_XH;
                    r_fv  <= 1'b1;
                    r_gx  <= {r_xh, r_xl};
`ifdef GYRO_AXIS_Z_EN
                    r_gy  <= {r_yh, r_yl};
                    r_gz  <= {r_zh, byte_in};
`else
                    r_gy  <= {r_yh, byte_in};
`endif
                end else begin
                    r_idx <= w_idx_cur + IDX_W'(1);
                end
            end else if (frame_start) begin
                r_idx <= IDX_XH;
            end
        end
    end

    assign gyro_x      = r_gx;
    assign gyro_y      = r_gy;
    assign frame_valid = r_fv;
`ifdef GYRO_AXIS_Z_EN
    assign gyro_z      = r_gz;
`endif

endmodule

// File: rtl/gyro_motion_detector.sv
// Debounced motion event from MPU6050 gyro frames: confirm, hold, then cooldown.
// Build option: GYRO_AXIS_Z_EN includes the Z axis in the over-threshold test.
module gyro_motion_detector
    import gyro_pkg::*;
#(
    parameter int unsigned THRESHOLD      = 2000,
    parameter int unsigned CONFIRM_FRAMES = 3,
    parameter int unsigned HOLD_CYCLES    = 25_000_000,
    parameter int unsigned HOLDOFF_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        frame_start,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
`ifdef GYRO_AXIS_Z_EN
    output logic [15:0] gyro_z,
`endif
    output logic        frame_valid,
    output logic        mover
);

    localparam int unsigned CONF_W = $clog2(CONFIRM_FRAMES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned OFF_W  = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONFIRM_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [OFF_W-1:0]  OFF_MAX  = OFF_W'(HOLDOFF_CYCLES);
    localparam logic [15:0]       THR      = 16'(THRESHOLD);

    logic [15:0]       w_gx, w_gy;
    logic              w_fv;
    logic              w_over;
    gyro_state_e       r_state, w_state_nx;
    logic [CONF_W-1:0] r_conf, w_conf_nx, w_conf_inc;
    logic [HOLD_W-1:0] r_hold, w_hold_nx;
    logic [OFF_W-1:0]  r_off, w_off_nx;
    logic              r_mover;

    gyro_frame_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .frame_start (frame_start),
        .gyro_x      (w_gx),
        .gyro_y      (w_gy),
`ifdef GYRO_AXIS_Z_EN
        .gyro_z      (gyro_z),
`endif
        .frame_valid (w_fv)
    );

    always_comb begin
`ifdef GYRO_AXIS_Z_EN
        w_over = (abs_sat(w_gx) > THR) || (abs_sat(w_gy) > THR) || (abs_sat(gyro_z) > THR);
`else
        w_over = (abs_sat(w_gx) > THR) || (abs_sat(w_gy) > THR);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_conf  <= '0;
            r_hold  <= '0;
            r_off   <= '0;
            r_mover <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_conf  <= w_conf_nx;
            r_hold  <= w_hold_nx;
            r_off   <= w_off_nx;
            r_mover <= (w_state_nx == ST_ACTIVE);
        end
    end

    // Next state and counters; hold/cooldown counters start at 1 on entry.
    always_comb begin
        w_state_nx = r_state;
        w_conf_nx  = r_conf;
        w_hold_nx  = r_hold;
        w_off_nx   = r_off;
        w_conf_inc = (r_conf == CONF_MAX) ? r_conf : r_conf + CONF_W'(1);
        case (r_state)
            ST_IDLE: begin
                if (w_fv && w_over) begin
                    w_conf_nx = CONF_W'(1);
                    if (CONFIRM_FRAMES == 1) begin
                        w_state_nx = ST_ACTIVE;
                        w_hold_nx  = HOLD_W'(1);
                    end else begin
                        w_state_nx = ST_ARMING;
                    end
                end
            end
            ST_ARMING: begin
                if (w_fv) begin
                    if (w_over) begin
                        w_conf_nx = w_conf_inc;
                        if (w_conf_inc >= CONF_MAX) begin
                            w_state_nx = ST_ACTIVE;
                            w_hold_nx  = HOLD_W'(1);
                        end
                    end else begin
                        w_conf_nx  = '0;
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (r_hold >= HOLD_MAX) begin
                    w_state_nx = ST_COOLDOWN;
                    w_hold_nx  = '0;
                    w_off_nx   = OFF_W'(1);
                end else begin
                    w_hold_nx = r_hold + HOLD_W'(1);
                end
            end
            ST_COOLDOWN: begin
                if (r_off >= OFF_MAX) begin
                    w_state_nx = ST_IDLE;
                    w_off_nx   = '0;
                    w_conf_nx  = '0;
                end else begin
                    w_off_nx = r_off + OFF_W'(1);
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
        if (!enable) begin
            w_state_nx = ST_IDLE;
            w_conf_nx  = '0;
            w_hold_nx  = '0;
            w_off_nx   = '0;
        end
    end

    assign gyro_x      = w_gx;
    assign gyro_y      = w_gy;
    assign frame_valid = w_fv;
    assign mover       = r_mover;

endmodule
